// File: rtl/td4_pkg.sv
// Shared types and sizing for the TD4 program memory loader.
package td4_pkg;

    localparam int TD4_AW    = 4;
    localparam int TD4_DW    = 8;
    localparam int TD4_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        VERIFY,
        RUN,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/td4_cksum_acc.sv
// Modulo-2**DW byte accumulator with synchronous clear and enable.
// acc_sum exposes acc + din so callers can test the post-add value early.
module td4_cksum_acc #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] acc_sum
);

    logic [DW-1:0] acc_reg;

    assign acc     = acc_reg;
    assign acc_sum = acc_reg + din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_sum;
        end
    end

endmodule

// File: rtl/td4_rom_loader.sv
// Streams a program image plus checksum into TD4 program memory, reads it
// back to verify, and only then releases the core from hold.
module td4_rom_loader
    import td4_pkg::*;
#(
    parameter int DEPTH = TD4_DEPTH,
    parameter int AW    = TD4_AW,
    parameter int DW    = TD4_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    loader_state_t state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          mem_we_next;
    logic [AW-1:0] mem_waddr_next, mem_raddr_next;
    logic [DW-1:0] mem_wdata_next;
    logic          cpu_hold_next, done_next, err_next;

    logic handshake, load_fire, check_fire, restart, cksum_ok, verify_last, verify_ok;

    // Index 0 accumulates the streamed image, index 1 the readback.
    logic          acc_clr [2];
    logic          acc_en  [2];
    logic [DW-1:0] acc_din [2];
    logic [DW-1:0] acc_val [2];
    logic [DW-1:0] acc_sum [2];

    assign acc_clr[0] = restart;
    assign acc_en[0]  = load_fire;
    assign acc_din[0] = in_data;
    assign acc_clr[1] = check_fire;
    assign acc_en[1]  = (state_reg == VERIFY);
    assign acc_din[1] = mem_rdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_acc
            td4_cksum_acc #(.DW(DW)) u_acc (
                .clk     (clk),
                .rst     (rst),
                .clr     (acc_clr[gi]),
                .en      (acc_en[gi]),
                .din     (acc_din[gi]),
                .acc     (acc_val[gi]),
                .acc_sum (acc_sum[gi])
            );
        end
    endgenerate

    assign in_ready    = (state_reg == LOAD) || (state_reg == CHECK);
    assign handshake   = in_valid && in_ready;
    assign load_fire   = handshake && (state_reg == LOAD);
    assign check_fire  = handshake && (state_reg == CHECK);
    assign restart     = start && ((state_reg == IDLE) || (state_reg == RUN) || (state_reg == ERROR));
    // In CHECK, acc_sum[0] is image sum plus the checksum byte on in_data.
    assign cksum_ok    = (acc_sum[0] == '0);
    assign verify_last = (state_reg == VERIFY) && (mem_raddr == ADDR_LAST);
    assign verify_ok   = (acc_sum[1] == acc_val[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RUN, ERROR: if (start) state_next = LOAD;
            LOAD:   if (load_fire && (addr_reg == ADDR_LAST)) state_next = CHECK;
            CHECK:  if (check_fire) state_next = cksum_ok ? VERIFY : ERROR;
            VERIFY: if (verify_last) state_next = verify_ok ? RUN : ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        addr_next      = addr_reg;
        mem_we_next    = load_fire;
        mem_waddr_next = mem_waddr;
        mem_wdata_next = mem_wdata;
        mem_raddr_next = mem_raddr;
        if (restart) begin
            addr_next = '0;
        end
        if (load_fire) begin
            addr_next      = addr_reg + ADDR_ONE;
            mem_waddr_next = addr_reg;
            mem_wdata_next = in_data;
        end
        if (check_fire) begin
            addr_next      = '0;
            mem_raddr_next = '0;
        end
        if (state_reg == VERIFY) begin
            mem_raddr_next = mem_raddr + ADDR_ONE;
        end
        // Status flags follow the state being entered, so they change on the same edge.
        cpu_hold_next = (state_next != RUN);
        done_next     = (state_next == RUN);
        err_next      = (state_next == ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_raddr <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            addr_reg  <= addr_next;
            mem_we    <= mem_we_next;
            mem_waddr <= mem_waddr_next;
            mem_wdata <= mem_wdata_next;
            mem_raddr <= mem_raddr_next;
            cpu_hold  <= cpu_hold_next;
            done      <= done_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_td4_rom_loader.sv
// Directed bench for td4_rom_loader with a simple program memory model.
module tb_td4_rom_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [3:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [16];
    logic [3:0] wlog_addr [32];
    logic [7:0] wlog_data [32];
    int         wr_cnt;
    logic       corrupt;

    always #5 clk = ~clk;

    td4_rom_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    assign mem_rdata = (corrupt && mem_raddr == 4'd5) ? 8'hFF : mem[mem_raddr];

    // Write port model and log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] = mem_wdata;
            if (wr_cnt < 32) begin
                wlog_addr[wr_cnt] = mem_waddr;
                wlog_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("[TB] byte %02h sent", b);
    endtask

    task automatic send_image(input logic [7:0] d_const, input bit use_addr, input int gap);
        for (int i = 0; i < 16; i++) begin
            send_byte(use_addr ? 8'(i) : d_const, gap);
        end
    endtask

    // Counts clock edges until done or err rises, bounded.
    task automatic wait_flag(output int n);
        n = 0;
        while (!done && !err && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_writes(input string tag, input logic [7:0] d_const, input bit use_addr);
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_waddr"}, {28'd0, wlog_addr[i]}, 32'(i));
            check({tag, "_wdata"}, {24'd0, wlog_data[i]}, use_addr ? 32'(i) : {24'd0, d_const});
        end
    endtask

    task automatic check_status(input string tag, input logic h, input logic d, input logic e);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_err"}, {31'd0, err}, {31'd0, e});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_waddr"}, {28'd0, mem_waddr}, 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, "_mem_raddr"}, {28'd0, mem_raddr}, 32'd0);
        check_status(tag, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        corrupt  = 1'b0;
        wr_cnt   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Nominal load: 0x00..0x0F sums to 0x78, checksum 0x88.
        pulse_start();
        check_status("load_start", 1'b1, 1'b0, 1'b0);
        wr_cnt = 0;
        send_image(8'h00, 1'b1, 0);
        send_byte(8'h88, 0);
        wait_flag(n);
        $display("[TB] nominal verify took %0d cycles", n);
        check("nom_verify_cycles", 32'(n), 32'd16);
        check_status("nom_end", 1'b0, 1'b1, 1'b0);
        check_writes("nom", 8'h00, 1'b1);

        // Restart from RUN, second image of 0xB3 (sum 0x30, checksum 0xD0).
        pulse_start();
        check_status("restart", 1'b1, 1'b0, 1'b0);
        check("restart_in_ready", {31'd0, in_ready}, 32'd1);
        wr_cnt = 0;
        send_image(8'hB3, 1'b0, 0);
        send_byte(8'hD0, 0);
        wait_flag(n);
        check("b3_verify_cycles", 32'(n), 32'd16);
        check_status("b3_end", 1'b0, 1'b1, 1'b0);
        check_writes("b3", 8'hB3, 1'b0);

        // Bad checksum goes straight to ERROR; no writes beyond the image.
        pulse_start();
        wr_cnt = 0;
        send_image(8'h00, 1'b1, 0);
        send_byte(8'h87, 0);
        check_status("badck", 1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("badck_wr_cnt", 32'(wr_cnt), 32'd16);
        check("badck_mem_we", {31'd0, mem_we}, 32'd0);
        check_status("badck_hold", 1'b1, 1'b0, 1'b1);

        // Readback corruption at address 5 from ERROR.
        pulse_start();
        check_status("from_err", 1'b1, 1'b0, 1'b0);
        wr_cnt  = 0;
        corrupt = 1'b1;
        send_image(8'h00, 1'b1, 0);
        send_byte(8'h88, 0);
        wait_flag(n);
        check("corrupt_verify_cycles", 32'(n), 32'd16);
        check_status("corrupt_end", 1'b1, 1'b0, 1'b1);
        corrupt = 1'b0;

        // Backpressure: valid high one cycle in three.
        pulse_start();
        wr_cnt = 0;
        send_image(8'h00, 1'b1, 2);
        send_byte(8'h88, 2);
        wait_flag(n);
        check("bp_verify_cycles", 32'(n), 32'd16);
        check_status("bp_end", 1'b0, 1'b1, 1'b0);
        check_writes("bp", 8'h00, 1'b1);

        // start during LOAD is ignored.
        pulse_start();
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) send_byte(8'(i), 0);
        pulse_start();
        $display("[TB] start pulsed mid-load");
        for (int i = 3; i < 16; i++) send_byte(8'(i), 0);
        send_byte(8'h88, 0);
        wait_flag(n);
        check("ign_verify_cycles", 32'(n), 32'd16);
        check_status("ign_end", 1'b0, 1'b1, 1'b0);
        check_writes("ign", 8'h00, 1'b1);

        // Asynchronous reset after 7 bytes, checked before the next edge.
        pulse_start();
        wr_cnt = 0;
        for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i), 0);
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] reset asserted mid-load");
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/td4_rom_loader.md
Name: td4_rom_loader

Overview:
Program loader for the TD4 core. It is the write side of the program memory, which the core only reads. It accepts a 16-byte program image plus a checksum byte over a valid/ready byte stream and writes the image into the program memory. It then reads the memory back to verify it, and releases the core from hold only when the image is intact.

Parameters:
DEPTH, 16, number of program words (must equal 2**AW)
AW, 4, program memory address width
DW, 8, program word width (op[7:4], imm[3:0])

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE, RUN or ERROR
in_valid  input  1  byte stream valid
in_data  input  DW  byte stream data
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  program memory write enable
mem_waddr  output  AW  program memory write address
mem_wdata  output  DW  program memory write data
mem_raddr  output  AW  readback address to program memory
mem_rdata  input  DW  readback data; combinational read of mem_raddr
cpu_hold  output  1  holds the TD4 core in reset; 0 only in RUN
done  output  1  image loaded and verified
err  output  1  checksum or verify failure

Behaviour:
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, cpu_hold=1, done=0, err=0. Internal addr=0, sum=0, vsum=0.
- States: IDLE, LOAD, CHECK, VERIFY, RUN, ERROR. All outputs are registered except in_ready, which is decoded from state (1 in LOAD and CHECK only).
- IDLE: start -> LOAD; addr=0, sum=0.
- LOAD, on each handshake (in_valid & in_ready):
  - next cycle: mem_we=1, mem_waddr=addr, mem_wdata=in_data (one-cycle write latency).
  - sum += in_data, modulo 2**DW; addr += 1.
  - the handshake at addr=DEPTH-1 -> CHECK; addr wraps to 0.
  - in_valid low stalls indefinitely; no timeout.
- mem_we is a single-cycle pulse per accepted byte and is never asserted outside the cycle after a LOAD handshake.
- CHECK: accepts one checksum byte c, which is never written to memory.
  - (sum + c) mod 2**DW == 0 -> VERIFY, with addr=0, vsum=0, mem_raddr=0.
  - otherwise -> ERROR.
- VERIFY: one address per cycle.
  - vsum += mem_rdata; mem_raddr increments.
  - after address DEPTH-1 is summed (DEPTH cycles), compare vsum with sum: equal -> RUN, else -> ERROR.
  - the last LOAD write completes before the first VERIFY read, because the CHECK handshake takes at least one cycle.
- RUN: cpu_hold=0, done=1. Stays until start or rst.
- ERROR: err=1, cpu_hold=1, done=0. Stays until start or rst.
- start in RUN or ERROR:
  - -> LOAD; addr=0, sum=0; done and err clear on the same edge.
  - cpu_hold reasserts on that edge, so the core is held before the first write.
- start in LOAD, CHECK or VERIFY is ignored.
- start and in_valid in the same IDLE cycle: the byte is not consumed, because in_ready is 0 in IDLE.
- rst mid-operation returns all registers to reset values immediately. Memory contents already written are left as they are; cpu_hold=1.

Decomposition:
- Shared package td4_pkg: state enum loader_state_t (IDLE, LOAD, CHECK, VERIFY, RUN, ERROR), constants TD4_AW=4, TD4_DW=8, TD4_DEPTH=16.
- One sub-module: td4_cksum_acc. Modulo-2**DW accumulator with clear and enable; instanced twice, once for sum and once for vsum.

Test Plan:
- Nominal load:
  - stimulus: reset, start, stream bytes 0x00..0x0F, then checksum 0x88 (the sum is 0x78).
  - response: 16 mem_we pulses at addresses 0..15 with data = address; VERIFY lasts 16 cycles; cpu_hold falls; done=1, err=0.
- Bad checksum: same image, checksum 0x87 -> ERROR; err=1, cpu_hold=1, done=0, and no mem_we after the 16th write.
- Readback corruption: memory model forces mem_rdata=0xFF at address 5 -> vsum mismatch -> ERROR; err=1 after the 16 VERIFY cycles.
- Backpressure gaps: in_valid toggles 1-0-0-1 throughout the load -> same writes as the nominal case, in order, with no duplicates or skips; final state RUN.
- Restart and reset:
  - start in RUN -> cpu_hold=1 and done=0 on the next edge; a second image of all 0xB3 bytes with checksum 0xD0 -> RUN.
  - rst asserted after 7 bytes -> all outputs return to reset values asynchronously; state IDLE.
- Ignored start: start pulsed during LOAD at byte 3 -> addr is not reset; the load completes normally with 16 writes.
